ifetch: RTL and testbench

Instruction fetch stage of the RV32 core: the consumer of the program counter. Each cycle it takes the current `pc`, issues a single-outstanding read to instruction memory over a req/ack handshake, and registers the returned word plus its address into the IF/ID boundary. It requests a PC stall while a fetch is pending and handles branch flush, so that no stale instruction reaches decode.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/if_skid.sv | 31 +++
 rtl/ifetch.sv | 106 ++++++++++
 tb/tb_ifetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, stall bit indices and the fetched-word record for the IF stage.
package ifetch_pkg;

    localparam int InsAddrBus = 32;
    localparam int InsBus     = 32;
    localparam int StallBus   = 6;
    localparam int StallPc    = 0;
    localparam int StallIf    = 1;

    localparam logic [InsBus-1:0] NopInst = 32'h0000_0013;

    typedef struct packed {
        logic [InsBus-1:0]     inst;
        logic [InsAddrBus-1:0] pc;
        logic                  valid;
    } fetch_word_t;

    localparam fetch_word_t FetchEmpty = '{inst: NopInst, pc: '0, valid: 1'b0};

endpackage

// File: rtl/if_skid.sv
// One-entry buffer that parks a completed fetch while IF/ID is frozen.
module if_skid
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        drain,
    input  fetch_word_t in_word,
    output fetch_word_t out_word
);

    fetch_word_t buf_q;

    // A branch kills the parked word even if a load arrives in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= FetchEmpty;
        end else if (clear) begin
            buf_q.valid <= 1'b0;
        end else if (load) begin
            buf_q <= in_word;
        end else if (drain) begin
            buf_q.valid <= 1'b0;
        end
    end

    assign out_word = buf_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: single-outstanding req/ack read from instruction memory,
// IF/ID register, PC stall request and branch flush handling.
module ifetch
    import ifetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [InsAddrBus-1:0] pc_i,
    input  logic [StallBus-1:0]   stall_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  mem_req_o,
    output logic [InsAddrBus-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [InsBus-1:0]     mem_rdata_i,
    output logic [InsBus-1:0]     inst_o,
    output logic [InsAddrBus-1:0] inst_pc_o,
    output logic                  inst_valid_o
);

    localparam logic [1:0] LAUNCH = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        stall_if;
    logic        ack_take;
    logic        hold_take;
    logic        skid_load;
    fetch_word_t acked_word;
    fetch_word_t skid_word;
    logic        unused_stall;

    assign stall_if     = stall_i[StallIf];
    assign unused_stall = ^{stall_i[StallBus-1:StallIf+1], stall_i[StallPc]};

    assign ack_take   = (state_q == WAIT) && mem_ack_i && !stall_if && !flush_i;
    assign skid_load  = (state_q == WAIT) && mem_ack_i &&  stall_if && !flush_i;
    assign hold_take  = (state_q == HOLD) && !stall_if && !flush_i;
    assign acked_word = '{inst: mem_rdata_i, pc: mem_addr_o, valid: 1'b1};

    // The PC may only move when a word enters IF/ID or a branch redirects it.
    assign stall_req_o = rst || !(flush_i || ack_take || hold_take);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LAUNCH: if (!flush_i) state_d = WAIT;
            WAIT: begin
                if (mem_ack_i)    state_d = (stall_if && !flush_i) ? HOLD : LAUNCH;
                else if (flush_i) state_d = DRAIN;
            end
            HOLD:   if (flush_i || !stall_if) state_d = LAUNCH;
            DRAIN:  if (mem_ack_i) state_d = LAUNCH;
            default: state_d = LAUNCH;
        endcase
    end

    // The request stays up through DRAIN because the bus cannot abort a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LAUNCH;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_o <= (state_d == WAIT) || (state_d == DRAIN);
            if ((state_q == LAUNCH) && !flush_i) mem_addr_o <= pc_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_o       <= NopInst;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (flush_i) begin
            inst_valid_o <= 1'b0;
        end else if (!stall_if) begin
            if (ack_take) begin
                inst_o       <= mem_rdata_i;
                inst_pc_o    <= mem_addr_o;
                inst_valid_o <= 1'b1;
            end else if (hold_take) begin
                inst_o       <= skid_word.inst;
                inst_pc_o    <= skid_word.pc;
                inst_valid_o <= skid_word.valid;
            end else begin
                inst_valid_o <= 1'b0;
            end
        end
    end

    if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (flush_i),
        .drain   (hold_take),
        .in_word (acked_word),
        .out_word(skid_word)
    );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed protocol scenarios followed by a random phase,
// with a PC register, a wait-state memory and a scoreboard of the program path.
module tb_ifetch;
    import ifetch_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [InsAddrBus-1:0] pc_reg;
    logic [StallBus-1:0]   stall_i = '0;
    logic                  flush_i = 1'b0;
    logic                  stall_req_o;
    logic                  mem_req_o;
    logic [InsAddrBus-1:0] mem_addr_o;
    logic                  mem_ack_i = 1'b0;
    logic [InsBus-1:0]     mem_rdata_i = '0;
    logic [InsBus-1:0]     inst_o;
    logic [InsAddrBus-1:0] inst_pc_o;
    logic                  inst_valid_o;

    logic [31:0] branch_target = '0;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          consumed = 0;
    int          fixed_wait = 0;

    ifetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_reg),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    // PC register: branch target on flush, +4 whenever the fetch stage lets go.
    always @(posedge clk or posedge rst) begin
        if (rst)               pc_reg <= '0;
        else if (flush_i)      pc_reg <= branch_target;
        else if (!stall_req_o) pc_reg <= pc_reg + 32'd4;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        if (addr == 32'h10) return 32'hDEAD_BEEF;
        return {addr[15:0] ^ 16'h5A3C, ~addr[15:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_output("rst_mem_addr", mem_addr_o, 32'd0);
        check_output("rst_inst", inst_o, NopInst);
        check_output("rst_inst_pc", inst_pc_o, 32'd0);
        check_output("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check_output("rst_stall_req", 32'(stall_req_o), 32'd1);
    endtask

    task automatic load_path(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Memory: latches the address when a request appears, acks after N waits.
    initial begin : memory
        bit          busy;
        logic [31:0] cur_addr;
        int          wait_left;
        busy = 0;
        cur_addr = '0;
        wait_left = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (rst) begin
                busy = 0;
            end else begin
                if (busy) begin
                    check_output("bus_req_held", 32'(mem_req_o), 32'd1);
                    check_output("bus_addr_held", mem_addr_o, cur_addr);
                end else if (mem_req_o) begin
                    busy = 1;
                    cur_addr = mem_addr_o;
                    wait_left = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
                end
                if (busy) begin
                    if (wait_left == 0) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = rom_word(cur_addr);
                        busy = 0;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // Scoreboard: an IF/ID word is consumed at an edge with no stall and no flush.
    initial begin : monitor
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                load_path(32'd0);
            end else if (flush_i) begin
                load_path(branch_target);
            end else if (inst_valid_o && !stall_i[StallIf]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL stream_underflow: got pc %h, expected no instruction", inst_pc_o);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check_output("stream_pc", inst_pc_o, exp_pc);
                    check_output("stream_inst", inst_o, rom_word(exp_pc));
                    consumed++;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic stall_if, input logic flush, input logic [31:0] target);
        stall_i[StallIf] = stall_if;
        flush_i = flush;
        branch_target = target;
    endtask

    initial begin : stimulus
        int since_flush;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Zero-wait memory: one instruction every two cycles.
        fixed_wait = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("zw_req", 32'(mem_req_o), 32'd1);
            check_output("zw_addr", mem_addr_o, 32'(4 * k));
            check_output("zw_stall_req", 32'(stall_req_o), 32'd0);
            @(negedge clk);
            check_output("zw_req_idle", 32'(mem_req_o), 32'd0);
            check_output("zw_valid", 32'(inst_valid_o), 32'd1);
            check_output("zw_inst_pc", inst_pc_o, 32'(4 * k));
            check_output("zw_inst", inst_o, rom_word(32'(4 * k)));
        end

        // Three wait states on 0x10.
        fixed_wait = 3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("ws_req", 32'(mem_req_o), 32'd1);
            check_output("ws_addr", mem_addr_o, 32'h10);
            check_output("ws_stall_req", 32'(stall_req_o), (k < 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check_output("ws_valid", 32'(inst_valid_o), 32'd1);
        check_output("ws_inst_pc", inst_pc_o, 32'h10);
        check_output("ws_inst", inst_o, 32'hDEAD_BEEF);
        check_output("ws_stall_req_after", 32'(stall_req_o), 32'd1);

        // Ack lands while IF/ID is frozen: word parks in the skid buffer.
        fixed_wait = 0;
        apply_stimulus(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check_output("hold_ack_stall_req", 32'(stall_req_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("hold_valid", 32'(inst_valid_o), 32'd1);
            check_output("hold_inst_pc", inst_pc_o, 32'h10);
            check_output("hold_req", 32'(mem_req_o), 32'd0);
            check_output("hold_stall_req", 32'(stall_req_o), 32'd1);
        end
        apply_stimulus(1'b0, 1'b0, 32'd0);
        #1;
        check_output("hold_release_stall_req", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        check_output("hold_out_valid", 32'(inst_valid_o), 32'd1);
        check_output("hold_out_pc", inst_pc_o, 32'h14);
        check_output("hold_out_inst", inst_o, rom_word(32'h14));
        check_output("hold_out_stall_req", 32'(stall_req_o), 32'd1);

        // Flush while a slow read is outstanding: drain, then fetch 0x100.
        fixed_wait = 4;
        @(negedge clk);
        check_output("drain_req0", 32'(mem_req_o), 32'd1);
        check_output("drain_addr0", mem_addr_o, 32'h18);
        apply_stimulus(1'b0, 1'b1, 32'h100);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_output("drain_req", 32'(mem_req_o), 32'd1);
            check_output("drain_addr", mem_addr_o, 32'h18);
            check_output("drain_valid", 32'(inst_valid_o), 32'd0);
            if (k == 3) check_output("drain_ack_stall_req", 32'(stall_req_o), 32'd1);
            else @(negedge clk);
        end
        fixed_wait = 0;
        @(negedge clk);
        check_output("drain_done_req", 32'(mem_req_o), 32'd0);
        check_output("drain_done_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk);
        check_output("target_req", 32'(mem_req_o), 32'd1);
        check_output("target_addr", mem_addr_o, 32'h100);
        @(negedge clk);
        check_output("target_valid", 32'(inst_valid_o), 32'd1);
        check_output("target_pc", inst_pc_o, 32'h100);

        // Flush coincident with ack.
        fixed_wait = 1;
        @(negedge clk);
        check_output("fa_addr", mem_addr_o, 32'h104);
        check_output("fa_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 32'h200);
        #1;
        check_output("fa_stall_req", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        fixed_wait = 0;
        check_output("fa_drop_valid", 32'(inst_valid_o), 32'd0);
        check_output("fa_drop_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        check_output("fa_next_addr", mem_addr_o, 32'h200);
        @(negedge clk);
        check_output("fa_next_pc", inst_pc_o, 32'h200);
        check_output("fa_next_valid", 32'(inst_valid_o), 32'd1);

        // Flush while parked in the skid buffer.
        apply_stimulus(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check_output("fh_addr", mem_addr_o, 32'h204);
        @(negedge clk);
        check_output("fh_held_pc", inst_pc_o, 32'h200);
        check_output("fh_req", 32'(mem_req_o), 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h300);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("fh_valid", 32'(inst_valid_o), 32'd0);
        check_output("fh_req_idle", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        check_output("fh_next_addr", mem_addr_o, 32'h300);
        @(negedge clk);
        check_output("fh_next_pc", inst_pc_o, 32'h300);
        check_output("fh_next_inst", inst_o, rom_word(32'h300));

        // Asynchronous reset in the middle of a read.
        fixed_wait = 5;
        @(negedge clk);
        check_output("mr_req", 32'(mem_req_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Random stalls, wait states and branches against the path scoreboard.
        fixed_wait = -1;
        since_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (since_flush >= 30 || $urandom_range(0, 15) == 0) begin
                apply_stimulus($urandom_range(0, 3) == 0, 1'b1, $urandom_range(0, 1023) << 2);
                since_flush = 0;
            end else begin
                apply_stimulus($urandom_range(0, 3) == 0, 1'b0, 32'd0);
                since_flush++;
            end
        end
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        repeat (10) @(negedge clk);
        check_output("progress", 32'(consumed >= 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
